// File: rtl/bridge_pkg.sv
// Shared types and helpers for the SRAM-like bus bridge.
// Also used by the MMU through vaddr_xlate.
package bridge_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_DONE
   } state_e;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   localparam logic [2:0] KSEG0 = 3'b100;
   localparam logic [2:0] KSEG1 = 3'b101;

   // Returns {size, addr[1:0]}; reads keep the CPU's low address bits.
   function automatic logic [3:0] wen_decode(
      input logic [3:0] wen,
      input logic [1:0] alo
   );
      logic [3:0] r;
      r = {SIZE_WORD, 2'b00};
      case (wen)
         4'b0000: r = {SIZE_WORD, alo};
         4'b1111: r = {SIZE_WORD, 2'b00};
         4'b0011: r = {SIZE_HALF, 2'b00};
         4'b1100: r = {SIZE_HALF, 2'b10};
         4'b0001: r = {SIZE_BYTE, 2'b00};
         4'b0010: r = {SIZE_BYTE, 2'b01};
         4'b0100: r = {SIZE_BYTE, 2'b10};
         4'b1000: r = {SIZE_BYTE, 2'b11};
         default: r = {SIZE_WORD, 2'b00};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/vaddr_xlate.sv
// Fixed kseg0/kseg1 virtual-to-physical mapping.
// Purely combinational.
module vaddr_xlate
   import bridge_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int TRANSLATE = 1
) (
   input  logic [ADDR_W-1:0] vaddr_i,
   output logic [ADDR_W-1:0] paddr_o,
   output logic              no_cache_o
);

   logic [2:0] seg;

   always_comb begin
      seg        = vaddr_i[ADDR_W-1 -: 3];
      paddr_o    = vaddr_i;
      no_cache_o = 1'b0;
      if (TRANSLATE != 0) begin
         if (seg == KSEG0 || seg == KSEG1) begin
            paddr_o = {3'b000, vaddr_i[ADDR_W-4:0]};
         end
         no_cache_o = (seg == KSEG1);
      end
   end

endmodule

// File: rtl/sram_like_bridge.sv
// Pipeline SRAM port to split-handshake SRAM-like bus adapter.
// Registers every bus output and holds read data across stalls.
module sram_like_bridge
   import bridge_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int TRANSLATE = 1
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                cpu_en,
   input  logic [DATA_W/8-1:0] cpu_wen,
   input  logic [ADDR_W-1:0]   cpu_addr,
   input  logic [DATA_W-1:0]   cpu_wdata,
   output logic [DATA_W-1:0]   cpu_rdata,
   output logic                cpu_stall,
   input  logic                pipe_stall,
   output logic                req,
   output logic                wr,
   output logic [1:0]          size,
   output logic [ADDR_W-1:0]   addr,
   output logic [DATA_W-1:0]   wdata,
   output logic                no_cache,
   input  logic                addr_ok,
   input  logic                data_ok,
   input  logic [DATA_W-1:0]   rdata
);

   state_e              state_q, state_d;
   logic                req_q, req_d;
   logic                wr_q, wr_d;
   logic [1:0]          size_q, size_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                nc_q, nc_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic [ADDR_W-1:0]   pa;
   logic                pa_nc;
   logic [3:0]          dec;

   vaddr_xlate #(
      .ADDR_W    (ADDR_W),
      .TRANSLATE (TRANSLATE)
   ) u_xlate (
      .vaddr_i    (cpu_addr),
      .paddr_o    (pa),
      .no_cache_o (pa_nc)
   );

   assign dec = wen_decode(cpu_wen[3:0], cpu_addr[1:0]);

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      wr_d    = wr_q;
      size_d  = size_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      nc_d    = nc_q;
      rdata_d = rdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (cpu_en) begin
               state_d     = S_ADDR;
               req_d       = 1'b1;
               wr_d        = |cpu_wen;
               size_d      = dec[3:2];
               addr_d      = pa;
               addr_d[1:0] = dec[1:0];
               wdata_d     = cpu_wdata;
               nc_d        = pa_nc;
            end
         end
         S_ADDR: begin
            // data_ok before the address handshake is a protocol error
            if (addr_ok) begin
               req_d = 1'b0;
               if (data_ok) begin
                  state_d = S_DONE;
                  if (!wr_q) rdata_d = rdata;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (data_ok) begin
               state_d = S_DONE;
               if (!wr_q) rdata_d = rdata;
            end
         end
         S_DONE: begin
            if (!pipe_stall) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         wr_q    <= 1'b0;
         size_q  <= 2'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         nc_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         wr_q    <= wr_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         nc_q    <= nc_d;
         rdata_q <= rdata_d;
      end
   end

   assign cpu_stall = cpu_en & (state_q != S_DONE);
   assign cpu_rdata = rdata_q;
   assign req       = req_q;
   assign wr        = wr_q;
   assign size      = size_q;
   assign addr      = addr_q;
   assign wdata     = wdata_q;
   assign no_cache  = nc_q;

endmodule

// File: tb/tb_sram_like_bridge.sv
// Scoreboard bench for sram_like_bridge.
// Expected bus requests and read data are queued at stimulus time.
module tb_sram_like_bridge;

   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        nc;
   } breq_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic        cpu_en;
   logic [3:0]  cpu_wen;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        pipe_stall;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        no_cache;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   int n_cmp  = 0;
   int n_fail = 0;

   breq_t       q_req[$];
   logic [31:0] q_rd[$];
   logic [31:0] last_rd;

   sram_like_bridge #(
      .DATA_W    (32),
      .ADDR_W    (32),
      .TRANSLATE (1)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .cpu_en     (cpu_en),
      .cpu_wen    (cpu_wen),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_stall  (cpu_stall),
      .pipe_stall (pipe_stall),
      .req        (req),
      .wr         (wr),
      .size       (size),
      .addr       (addr),
      .wdata      (wdata),
      .no_cache   (no_cache),
      .addr_ok    (addr_ok),
      .data_ok    (data_ok),
      .rdata      (rdata)
   );

   always #5 clk = ~clk;

   function automatic breq_t model(
      input logic [31:0] va,
      input logic [3:0]  wen,
      input logic [31:0] wd
   );
      breq_t m;
      logic [2:0] seg;
      seg = va[31:29];
      m.addr  = (seg == 3'b100 || seg == 3'b101) ? {3'b000, va[28:0]} : va;
      m.nc    = (seg == 3'b101);
      m.wr    = (wen != 4'b0000);
      m.wdata = wd;
      m.size  = 2'd2;
      case (wen)
         4'b0000: m.size = 2'd2;
         4'b0011: begin m.size = 2'd1; m.addr[1:0] = 2'b00; end
         4'b1100: begin m.size = 2'd1; m.addr[1:0] = 2'b10; end
         4'b0001: begin m.size = 2'd0; m.addr[1:0] = 2'b00; end
         4'b0010: begin m.size = 2'd0; m.addr[1:0] = 2'b01; end
         4'b0100: begin m.size = 2'd0; m.addr[1:0] = 2'b10; end
         4'b1000: begin m.size = 2'd0; m.addr[1:0] = 2'b11; end
         default: begin m.size = 2'd2; m.addr[1:0] = 2'b00; end
      endcase
      return m;
   endfunction

   function automatic breq_t bus_now();
      breq_t b;
      b = {wr, size, addr, wdata, no_cache};
      return b;
   endfunction

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic issue(
      input logic [31:0] va,
      input logic [3:0]  wen,
      input logic [31:0] wd
   );
      cpu_en    = 1'b1;
      cpu_addr  = va;
      cpu_wen   = wen;
      cpu_wdata = wd;
      q_req.push_back(model(va, wen, wd));
   endtask

   task automatic pop_req(output breq_t e);
      if (q_req.size() == 0) begin
         n_fail++;
         $display("FAIL sb_req_empty got empty queue exp entry");
         e = '0;
      end else begin
         e = q_req.pop_front();
      end
   endtask

   task automatic pop_rd(output logic [31:0] e);
      if (q_rd.size() == 0) begin
         n_fail++;
         $display("FAIL sb_rd_empty got empty queue exp entry");
         e = '0;
      end else begin
         e = q_rd.pop_front();
      end
      last_rd = e;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      cpu_en = 1'b0; cpu_wen = '0; cpu_addr = '0; cpu_wdata = '0;
      pipe_stall = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; rdata = '0;
      smp();
      n_cmp++;
      if ({req, bus_now()} !== '0) begin
         n_fail++;
         $display("FAIL reset_bus got %h exp 0", {req, bus_now()});
      end
      n_cmp++;
      if (cpu_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_rdata got %h exp 0", cpu_rdata);
      end
      n_cmp++;
      if (cpu_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_stall_idle got %b exp 0", cpu_stall);
      end
      cpu_en = 1'b1;
      #1;
      n_cmp++;
      if (cpu_stall !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_stall_en got %b exp 1", cpu_stall);
      end
      cpu_en = 1'b0;
      nxt();
      resetn = 1'b1;
   endtask

   task automatic test_word_read();
      breq_t e;
      logic [31:0] er;
      nxt();
      issue(32'hBFC0_0000, 4'b0000, 32'h0);
      smp();
      n_cmp++;
      if ({req, cpu_stall} !== 2'b01) begin
         n_fail++;
         $display("FAIL rd_c0 got req/stall %b exp 01", {req, cpu_stall});
      end
      nxt();
      addr_ok = 1'b1;
      smp();
      pop_req(e);
      n_cmp++;
      if (req !== 1'b1 || bus_now() !== e) begin
         n_fail++;
         $display("FAIL rd_c1_req got %b %h exp 1 %h", req, bus_now(), e);
      end
      nxt();
      addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h3C08_BFAF;
      q_rd.push_back(32'h3C08_BFAF);
      smp();
      n_cmp++;
      if ({req, cpu_stall} !== 2'b01) begin
         n_fail++;
         $display("FAIL rd_c2 got req/stall %b exp 01", {req, cpu_stall});
      end
      nxt();
      data_ok = 1'b0; rdata = '0; pipe_stall = 1'b0;
      smp();
      pop_rd(er);
      n_cmp++;
      if (cpu_stall !== 1'b0 || cpu_rdata !== er) begin
         n_fail++;
         $display("FAIL rd_c3 got %b %h exp 0 %h", cpu_stall, cpu_rdata, er);
      end
      cpu_en = 1'b0;
   endtask

   task automatic test_byte_store();
      breq_t e;
      nxt();
      issue(32'h8000_1000, 4'b0100, 32'hAABB_CCDD);
      nxt();
      addr_ok = 1'b1;
      smp();
      pop_req(e);
      n_cmp++;
      if (req !== 1'b1 || bus_now() !== e) begin
         n_fail++;
         $display("FAIL st_req got %b %h exp 1 %h", req, bus_now(), e);
      end
      nxt();
      addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h5555_5555;
      nxt();
      data_ok = 1'b0; pipe_stall = 1'b0;
      smp();
      n_cmp++;
      if (cpu_stall !== 1'b0 || cpu_rdata !== last_rd) begin
         n_fail++;
         $display("FAIL st_done got %b %h exp 0 %h", cpu_stall, cpu_rdata, last_rd);
      end
      cpu_en = 1'b0;
   endtask

   task automatic test_addr_wait();
      breq_t e;
      nxt();
      issue(32'h0040_0010, 4'b1100, 32'h1122_3344);
      nxt();
      pop_req(e);
      for (int i = 0; i < 4; i++) begin
         data_ok = (i == 1);
         smp();
         n_cmp++;
         if (req !== 1'b1 || bus_now() !== e) begin
            n_fail++;
            $display("FAIL wait_hold%0d got %b %h exp 1 %h", i, req, bus_now(), e);
         end
         nxt();
      end
      addr_ok = 1'b1;
      smp();
      n_cmp++;
      if (req !== 1'b1 || bus_now() !== e) begin
         n_fail++;
         $display("FAIL wait_ack got %b %h exp 1 %h", req, bus_now(), e);
      end
      nxt();
      addr_ok = 1'b0; data_ok = 1'b1;
      smp();
      n_cmp++;
      if ({req, cpu_stall} !== 2'b01) begin
         n_fail++;
         $display("FAIL wait_req_drop got %b exp 01", {req, cpu_stall});
      end
      nxt();
      data_ok = 1'b0; pipe_stall = 1'b0;
      smp();
      n_cmp++;
      if (cpu_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL wait_done got %b exp 0", cpu_stall);
      end
      cpu_en = 1'b0;
   endtask

   task automatic test_sizes();
      logic [3:0] pats [6];
      breq_t e;
      pats = '{4'b0001, 4'b0010, 4'b1000, 4'b0011, 4'b0101, 4'b1111};
      for (int k = 0; k < 6; k++) begin
         nxt();
         issue((k % 2) ? 32'hA000_2004 + k : 32'h0000_2008 + k,
               pats[k], $urandom);
         nxt();
         addr_ok = 1'b1; data_ok = 1'b1;
         smp();
         pop_req(e);
         n_cmp++;
         if (req !== 1'b1 || bus_now() !== e) begin
            n_fail++;
            $display("FAIL size_%b got %b %h exp 1 %h", pats[k], req, bus_now(), e);
         end
         nxt();
         addr_ok = 1'b0; data_ok = 1'b0; pipe_stall = 1'b0;
         smp();
         n_cmp++;
         if (cpu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL size_done_%b got %b exp 0", pats[k], cpu_stall);
         end
         cpu_en = 1'b0;
      end
   endtask

   task automatic test_pipe_hold_b2b();
      breq_t e;
      logic [31:0] er;
      nxt();
      issue(32'h9FC0_0004, 4'b0000, 32'h0);
      nxt();
      addr_ok = 1'b1;
      smp();
      pop_req(e);
      n_cmp++;
      if (bus_now() !== e) begin
         n_fail++;
         $display("FAIL hold_req got %h exp %h", bus_now(), e);
      end
      nxt();
      addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
      q_rd.push_back(32'hDEAD_BEEF);
      nxt();
      data_ok = 1'b0; pipe_stall = 1'b1;
      pop_rd(er);
      for (int i = 0; i < 3; i++) begin
         rdata = $urandom;
         smp();
         n_cmp++;
         if (cpu_stall !== 1'b0 || cpu_rdata !== er) begin
            n_fail++;
            $display("FAIL hold_cyc%0d got %b %h exp 0 %h", i, cpu_stall, cpu_rdata, er);
         end
         nxt();
      end
      pipe_stall = 1'b0;
      smp();
      n_cmp++;
      if (cpu_rdata !== er) begin
         n_fail++;
         $display("FAIL hold_release got %h exp %h", cpu_rdata, er);
      end
      issue(32'hBFC0_0010, 4'b0000, 32'h0);
      nxt();
      smp();
      n_cmp++;
      if ({req, cpu_stall} !== 2'b01) begin
         n_fail++;
         $display("FAIL b2b_idle got req/stall %b exp 01", {req, cpu_stall});
      end
      nxt();
      addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'h0123_4567;
      q_rd.push_back(32'h0123_4567);
      smp();
      pop_req(e);
      n_cmp++;
      if (req !== 1'b1 || bus_now() !== e) begin
         n_fail++;
         $display("FAIL b2b_req got %b %h exp 1 %h", req, bus_now(), e);
      end
      nxt();
      addr_ok = 1'b0; data_ok = 1'b0;
      smp();
      pop_rd(er);
      n_cmp++;
      if (cpu_stall !== 1'b0 || cpu_rdata !== er) begin
         n_fail++;
         $display("FAIL b2b_done got %b %h exp 0 %h", cpu_stall, cpu_rdata, er);
      end
      cpu_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      breq_t e;
      logic [31:0] er;
      nxt();
      issue(32'hA000_0102, 4'b0000, 32'h0);
      nxt();
      addr_ok = 1'b1;
      smp();
      pop_req(e);
      n_cmp++;
      if (bus_now() !== e) begin
         n_fail++;
         $display("FAIL rst_req got %h exp %h", bus_now(), e);
      end
      nxt();
      addr_ok = 1'b0;
      smp();
      #2;
      resetn = 1'b0;
      cpu_en = 1'b0;
      #1;
      n_cmp++;
      if ({req, cpu_stall} !== 2'b00 || cpu_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_mid got %b %h exp 00 0", {req, cpu_stall}, cpu_rdata);
      end
      cpu_en = 1'b1;
      #1;
      n_cmp++;
      if (cpu_stall !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_stall got %b exp 1", cpu_stall);
      end
      cpu_en = 1'b0;
      nxt();
      resetn = 1'b1;
      nxt();
      issue(32'hA000_0102, 4'b0000, 32'h0);
      nxt();
      smp();
      pop_req(e);
      n_cmp++;
      if (req !== 1'b1 || bus_now() !== e) begin
         n_fail++;
         $display("FAIL rst_new_req got %b %h exp 1 %h", req, bus_now(), e);
      end
      addr_ok = 1'b1;
      nxt();
      addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'hCAFE_F00D;
      q_rd.push_back(32'hCAFE_F00D);
      nxt();
      data_ok = 1'b0; pipe_stall = 1'b0;
      smp();
      pop_rd(er);
      n_cmp++;
      if (cpu_stall !== 1'b0 || cpu_rdata !== er) begin
         n_fail++;
         $display("FAIL rst_new_done got %b %h exp 0 %h", cpu_stall, cpu_rdata, er);
      end
      cpu_en = 1'b0;
   endtask

   task automatic test_same_cycle();
      breq_t e;
      logic [31:0] er;
      nxt();
      data_ok = 1'b1; rdata = 32'hFFFF_0000;
      nxt();
      smp();
      n_cmp++;
      if (req !== 1'b0 || cpu_rdata !== last_rd) begin
         n_fail++;
         $display("FAIL spur_idle got %b %h exp 0 %h", req, cpu_rdata, last_rd);
      end
      data_ok = 1'b0;
      nxt();
      issue(32'hBFC0_0020, 4'b0000, 32'h0);
      smp();
      n_cmp++;
      if (cpu_stall !== 1'b1) begin
         n_fail++;
         $display("FAIL same_c0 got %b exp 1", cpu_stall);
      end
      nxt();
      addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'h1357_9BDF;
      q_rd.push_back(32'h1357_9BDF);
      smp();
      pop_req(e);
      n_cmp++;
      if (req !== 1'b1 || bus_now() !== e) begin
         n_fail++;
         $display("FAIL same_req got %b %h exp 1 %h", req, bus_now(), e);
      end
      nxt();
      addr_ok = 1'b0; data_ok = 1'b0; pipe_stall = 1'b0;
      smp();
      pop_rd(er);
      n_cmp++;
      if ({req, cpu_stall} !== 2'b00 || cpu_rdata !== er) begin
         n_fail++;
         $display("FAIL same_done got %b %h exp 00 %h", {req, cpu_stall}, cpu_rdata, er);
      end
      cpu_en = 1'b0;
      nxt();
   endtask

   initial begin
      last_rd = '0;
      test_reset();
      test_word_read();
      test_byte_store();
      test_addr_wait();
      test_sizes();
      test_pipe_hold_b2b();
      test_reset_mid();
      test_same_cycle();
      n_cmp++;
      if (q_req.size() != 0 || q_rd.size() != 0) begin
         n_fail++;
         $display("FAIL sb_leftover got %0d/%0d exp 0/0", q_req.size(), q_rd.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sram_like_bridge.md
# sram_like_bridge

Parametrised single-channel adapter between the CPU pipeline's SRAM-style memory port (single-cycle en/wen/addr/wdata/rdata) and a split-handshake SRAM-like bus (req/addr_ok/data_ok). It sits between the datapath and the cache/AXI side, with one instance for instruction fetch and one for data. Each instance performs fixed kseg0/kseg1 virtual-to-physical translation, derives bus size from byte enables, and generates the stall that freezes the pipeline until the transfer completes. It holds read data while another source keeps the pipeline stalled.

## Interface
Parameters:
- DATA_W, 32, data width; byte-enable width is DATA_W/8; only 32 is required to work
- ADDR_W, 32, address width
- TRANSLATE, 1, 1 = apply kseg0/kseg1 mapping; 0 = paddr equals vaddr and no_cache is 0

Ports:
- Clock and reset: one clock, `clk`; reset `resetn` is asynchronous and active-low.
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- cpu_en  in  1  access request from the pipeline, held until cpu_stall falls
- cpu_wen  in  DATA_W/8  byte write enables; 0 = read
- cpu_addr  in  ADDR_W  virtual address
- cpu_wdata  in  DATA_W  store data, already lane-aligned
- cpu_rdata  out  DATA_W  read data, valid while state is DONE
- cpu_stall  out  1  combinational; freezes the pipeline
- pipe_stall  in  1  global pipeline stall (OR of all stall sources)
- req  out  1  bus request
- wr  out  1  1 = write
- size  out  2  0 = byte, 1 = half, 2 = word
- addr  out  ADDR_W  physical address
- wdata  out  DATA_W  write data
- no_cache  out  1  uncached access (kseg1)
- addr_ok  in  1  request accepted
- data_ok  in  1  data returned or write completed
- rdata  in  DATA_W  bus read data

## Operation
- States:
  - IDLE: no transfer.
  - ADDR: req=1, waiting for addr_ok.
  - DATA: waiting for data_ok.
  - DONE: result held while the pipeline is still stalled.
- IDLE → ADDR when cpu_en=1. On this transition, latch wr, size, addr, wdata and no_cache.
- ADDR → DATA when addr_ok=1 and data_ok=0.
- ADDR → DONE when addr_ok=1 and data_ok=1 in the same cycle.
- DATA → DONE when data_ok=1. On a read, capture rdata into cpu_rdata.
- DONE → IDLE when pipe_stall=0. The pipeline advances in that cycle.
- DONE stays in DONE when pipe_stall=1, with cpu_rdata unchanged.
- cpu_stall = cpu_en & (state != DONE).
- data_ok in IDLE or ADDR (before addr_ok) is a protocol violation and is ignored.
- Size and address low bits, derived from cpu_wen:
  - 1111: size 2, addr[1:0]=00.
  - 0011 / 1100: size 1, addr[1:0]=00 / 10.
  - Single set bit i: size 0, addr[1:0]=i.
  - Any other nonzero pattern: size 2, addr[1:0]=00.
  - Read: size 2, addr[1:0] taken from cpu_addr.
- Translation when TRANSLATE=1:
  - vaddr[31:29] = 100 (kseg0) or 101 (kseg1) → paddr = {000, vaddr[28:0]}; otherwise paddr = vaddr.
  - no_cache = (vaddr[31:29] == 101).
- Reset mid-operation: force IDLE and abandon any bus transaction. The bus side shares resetn.

## Timing
- Reset values:
  - State IDLE.
  - req, wr, size, addr, wdata, no_cache and cpu_rdata are all 0.
  - cpu_stall is 0 unless cpu_en is 1.
- All bus outputs are registered. req rises one cycle after cpu_en is sampled in IDLE.
- Minimum latency:
  - cpu_en at cycle 0, req at cycle 1, addr_ok at cycle 1, data_ok at cycle 2.
  - State is DONE at cycle 3; cpu_stall is low at cycle 3; 3 stall cycles.
- With addr_ok and data_ok both in cycle 1: DONE at cycle 2, 2 stall cycles.
- req stays high and addr, size, wr, wdata stay stable from request until addr_ok is sampled. req drops the cycle after addr_ok.
- cpu_rdata is stable from entry into DONE until the DONE → IDLE transition.
- Back-to-back: a new cpu_en is accepted at the earliest in the cycle after DONE → IDLE.

## Structure
- Shared package `bridge_pkg`:
  - State enum.
  - SIZE_BYTE/HALF/WORD constants.
  - KSEG0 = 3'b100, KSEG1 = 3'b101.
- Sub-module `vaddr_xlate`: combinational, computes paddr and no_cache from the virtual address. It is also reusable by the MMU.

## Test plan
- Word read of 0xBFC00000, addr_ok at cycle 1, data_ok at cycle 2 with rdata 0x3C08BFAF → addr=0x1FC00000, no_cache=1, size=2, wr=0; cpu_rdata=0x3C08BFAF and cpu_stall=0 at cycle 3.
- Byte store with cpu_wen=0100 to 0x80001000 → wr=1, size=0, addr=0x00001002, no_cache=0, wdata passed unchanged.
- addr_ok withheld for 4 cycles → req held high with all fields stable; req low the cycle after addr_ok.
- pipe_stall held high 3 cycles after DONE, with rdata changing on the bus → cpu_rdata holds the captured value; return to IDLE in the first cycle with pipe_stall=0.
- resetn pulsed low while in DATA → immediate IDLE, req=0, cpu_rdata=0; a new request after reset completes normally.
- Same-cycle addr_ok and data_ok → ADDR → DONE directly; spurious data_ok in IDLE → no state change.
